// File: rtl/cos_accumulator.sv
// cos_accumulator: downstream stage of the cosine accelerator.
// Accumulates a batch of `len` signed fixed-point samples into a wide
// saturating sum and reports it with a one-cycle done pulse.
//
// Handshake: a sample is consumed on a rising clk edge when
// in_valid && in_ready. in_ready is high only in ACCUM with clk_en=1 and
// does not depend on in_valid. The upstream stage must hold in_data stable
// while in_valid is high and in_ready is low.
module cos_accumulator #(
    parameter int IN_W  = 24,
    parameter int FRAC  = 22,
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             done,
    output logic [ACC_W-1:0] sum,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // The sum keeps the input binary point, so FRAC only constrains legality.
    generate
        if (ACC_W <= IN_W || FRAC >= IN_W) begin : g_bad_params
            $error("cos_accumulator: need ACC_W > IN_W and FRAC < IN_W");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_sum;
    logic             r_overflow;

    logic [ACC_W:0]   w_in_ext;
    logic [ACC_W:0]   w_add;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sat;
    logic             w_accept;

    // One guard bit above the accumulator detects overflow of a single add;
    // the result is clamped per add so saturation never wraps mid-batch.
    always_comb begin
        w_in_ext = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
        w_add    = {r_acc[ACC_W-1], r_acc} + w_in_ext;
        w_ovf    = w_add[ACC_W] ^ w_add[ACC_W-1];
        w_sat    = w_add[ACC_W-1:0];
        if (w_ovf) begin
            w_sat = w_add[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    assign in_ready  = clk_en && (r_state == S_ACCUM);
    assign w_accept  = in_valid && in_ready;
    assign done      = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

    // Batch FSM, accumulator, sample counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc      <= '0;
                        r_sum      <= '0;
                        r_overflow <= 1'b0;
                        if (len != '0) begin
                            r_cnt   <= len;
                            r_state <= S_ACCUM;
                        end else begin
                            // Zero-length batch reports an empty sum at once.
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sat;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_ovf) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_cnt == CNT_W'(1)) begin
                            r_sum   <= w_sat;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cos_accumulator.sv
// Directed bench for cos_accumulator. Two instances share all inputs: the
// default 40-bit accumulator and a 26-bit one used to reach saturation.
// Expected batch results are queued when a batch starts; monitors pop them
// on each rising done.
module tb_cos_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [15:0] len;
    logic        in_valid;
    logic [23:0] in_data;

    logic        rdy40, done40, ovf40, busy40;
    logic [39:0] sum40;
    logic [1:0]  st40;
    logic        rdy26, done26, ovf26, busy26;
    logic [25:0] sum26;
    logic [1:0]  st26;

    logic [40:0] exp_q[$];
    logic [26:0] exp26_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int a0;

    always #5 clk = ~clk;

    cos_accumulator dut40 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(rdy40), .in_data(in_data),
        .done(done40), .sum(sum40), .overflow(ovf40), .busy(busy40),
        .dbg_state(st40)
    );

    cos_accumulator #(.ACC_W(26)) dut26 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(rdy26), .in_data(in_data),
        .done(done26), .sum(sum26), .overflow(ovf26), .busy(busy26),
        .dbg_state(st26)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [39:0] s40, input logic o40,
                            input logic [25:0] s26, input logic o26);
        exp_q.push_back({o40, s40});
        exp26_q.push_back({o26, s26});
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [23:0] d);
        bit got = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (rdy40) got = 1;
            step();
        end
        if (!got) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Accept counter and 40-bit result monitor.
    initial begin
        logic prev = 1'b0;
        logic [40:0] e;
        forever begin
            @(negedge clk);
            if (in_valid && rdy40) n_acc++;
            if (done40 && !prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done40", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum40", 64'(sum40), 64'(e[39:0]));
                    check("ovf40", 64'(ovf40), 64'(e[40]));
                end
            end
            prev = done40;
        end
    end

    // 26-bit result monitor.
    initial begin
        logic prev = 1'b0;
        logic [26:0] e;
        forever begin
            @(negedge clk);
            if (done26 && !prev) begin
                if (exp26_q.size() == 0) begin
                    check("unexpected_done26", 64'd1, 64'd0);
                end else begin
                    e = exp26_q.pop_front();
                    check("sum26", 64'(sum26), 64'(e[25:0]));
                    check("ovf26", 64'(ovf26), 64'(e[26]));
                end
            end
            prev = done26;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0;
        #12;
        check("rst_state", 64'(st40), 64'd0);
        check("rst_sum", 64'(sum40), 64'd0);
        check("rst_done", 64'(done40), 64'd0);
        check("rst_ovf", 64'(ovf40), 64'd0);
        check("rst_ready", 64'(rdy40), 64'd0);
        check("rst_busy", 64'(busy40), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // 1: four samples of +1.0, continuous valid.
        push_exp(40'h0001000000, 1'b0, 26'h1000000, 1'b0);
        a0 = n_acc;
        do_start(16'd4);
        check("t1_busy", 64'(busy40), 64'd1);
        check("t1_state", 64'(st40), 64'd1);
        repeat (3) send(24'h400000);
        check("t1_done_early", 64'(done40), 64'd0);
        send(24'h400000);
        check("t1_done", 64'(done40), 64'd1);
        check("t1_ready_after", 64'(rdy40), 64'd0);
        check("t1_accepts", 64'(n_acc - a0), 64'd4);
        step();
        check("t1_done_pulse", 64'(done40), 64'd0);
        check("t1_idle_busy", 64'(busy40), 64'd0);

        // 2: -1.0 + 0.5 + 0.25 with valid gaps and clk_en stalls.
        push_exp(40'hFFFFF00000, 1'b0, 26'h3F00000, 1'b0);
        a0 = n_acc;
        do_start(16'd3);
        send(24'hC00000);
        step(); step();
        send(24'h200000);
        in_valid = 1'b1; in_data = 24'h100000; clk_en = 1'b0;
        step();
        check("t2_ready_stall", 64'(rdy40), 64'd0);
        step();
        check("t2_state_stall", 64'(st40), 64'd1);
        clk_en = 1'b1;
        send(24'h100000);
        check("t2_done", 64'(done40), 64'd1);
        clk_en = 1'b0;
        step();
        check("t2_done_hold1", 64'(done40), 64'd1);
        step();
        check("t2_done_hold2", 64'(done40), 64'd1);
        clk_en = 1'b1;
        step();
        check("t2_done_drop", 64'(done40), 64'd0);
        check("t2_accepts", 64'(n_acc - a0), 64'd3);

        // 3: zero-length batch with valid held high.
        push_exp(40'h0, 1'b0, 26'h0, 1'b0);
        a0 = n_acc;
        in_valid = 1'b1; in_data = 24'h7FFFFF;
        do_start(16'd0);
        check("t3_done", 64'(done40), 64'd1);
        check("t3_ready_done", 64'(rdy40), 64'd0);
        step();
        check("t3_done_drop", 64'(done40), 64'd0);
        check("t3_ready_idle", 64'(rdy40), 64'd0);
        check("t3_accepts", 64'(n_acc - a0), 64'd0);
        in_valid = 1'b0;

        // 4: eight +1.0 samples saturate the 26-bit sum; next batch clears overflow.
        push_exp(40'h0002000000, 1'b0, 26'h1FFFFFF, 1'b1);
        do_start(16'd8);
        repeat (8) send(24'h400000);
        check("t4_ovf26", 64'(ovf26), 64'd1);
        step();
        push_exp(40'h1, 1'b0, 26'h1, 1'b0);
        do_start(16'd1);
        check("t4_ovf_clear", 64'(ovf26), 64'd0);
        send(24'h000001);
        step();

        // 5: asynchronous reset after 2 of 5 accepts.
        do_start(16'd5);
        send(24'h012345);
        send(24'h012345);
        #3 rst = 1'b1;
        #1;
        check("t5_state", 64'(st40), 64'd0);
        check("t5_sum", 64'(sum40), 64'd0);
        check("t5_done", 64'(done40), 64'd0);
        check("t5_busy", 64'(busy40), 64'd0);
        check("t5_ready", 64'(rdy40), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        push_exp(40'h123456, 1'b0, 26'h123456, 1'b0);
        do_start(16'd1);
        send(24'h123456);
        step();

        // 6: start pulsed in ACCUM and DONE is ignored.
        push_exp(40'h200000, 1'b0, 26'h200000, 1'b0);
        do_start(16'd2);
        start = 1'b1; len = 16'd5;
        send(24'h100000);
        send(24'h100000);
        check("t6_done_len2", 64'(done40), 64'd1);
        step();
        start = 1'b0;
        check("t6_idle", 64'(st40), 64'd0);
        check("t6_busy", 64'(busy40), 64'd0);
        step();
        check("t6_still_idle", 64'(st40), 64'd0);

        repeat (3) step();
        check("queue40_empty", 64'(exp_q.size()), 64'd0);
        check("queue26_empty", 64'(exp26_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cos_accumulator.md
Name: cos_accumulator

Overview:
- Downstream stage of the cosine accelerator. Consumes the 24-bit signed fixed-point cosine results (y_fx) one sample at a time and accumulates a run of LEN samples into a wide saturating sum.
- Reports the sum with a one-cycle done pulse, so software issues one start per batch instead of reading every result.
- Uses the same clk/clk_en/rst conventions as the accelerator so both can share one custom-instruction slot.

Parameters:
- IN_W, 24: input sample width, signed two's complement, same fixed-point format as y_fx.
- FRAC, 22: fractional bits of the input. Informational only; the sum keeps the same binary point.
- ACC_W, 40: accumulator/sum width, signed. Must satisfy ACC_W > IN_W.
- CNT_W, 16: width of the sample-count field.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  clock enable; when low, all state is frozen
- start  in  1  begin a new batch; sampled only in IDLE
- len  in  CNT_W  number of samples in the batch; captured on the accepted start
- in_valid  in  1  in_data carries a cosine result
- in_ready  out  1  block accepts a sample this cycle
- in_data  in  IN_W  signed fixed-point sample
- done  out  1  one-cycle pulse: sum is final
- sum  out  ACC_W  signed accumulated result; held until the next start
- overflow  out  1  sticky saturation flag for the current batch
- busy  out  1  high in ACCUM and DONE states

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, acc=0, cnt=0
  - sum=0, done=0, overflow=0, in_ready=0, busy=0
- clk_en=0: no register changes, including the FSM, cnt, acc and done. in_ready is forced to 0. A done pulse already high stays high until the next enabled edge.
- Every edge transition below requires clk_en=1.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 and len>0: cnt<=len, acc<=0, overflow<=0, sum<=0; go to ACCUM.
  - start=1 and len==0: sum<=0, overflow<=0; go to DONE. The result is a zero-length batch.
- ACCUM:
  - in_ready=1, busy=1.
  - A sample is accepted when in_valid & in_ready & clk_en.
  - On accept: acc<=sat(acc + sext(in_data)) and cnt<=cnt-1.
  - If cnt==1 on accept: sum<=sat(acc + sext(in_data)) and go to DONE.
  - start is ignored in this state.
- DONE:
  - done=1 (registered, exactly one enabled cycle), in_ready=0, busy=1.
  - Next enabled edge returns to IDLE.
  - start in DONE is ignored; it must be re-asserted in IDLE.
- Latency: done rises on the edge after the final sample is accepted, i.e. 1 cycle. Minimum batch of N samples with continuous valid: start edge, then N accept cycles, then done.
- Arithmetic:
  - in_data is sign-extended to ACC_W+1 bits before adding.
  - If the result exceeds 2^(ACC_W-1)-1 or falls below -2^(ACC_W-1), clamp to that limit and set overflow=1.
  - overflow is sticky until the next accepted start or reset.
  - Saturation is applied per add, not only at the end.
- sum is stable from the DONE entry until the next accepted start (cleared to 0 there).
- Reset mid-ACCUM or mid-DONE aborts the batch immediately; outputs return to their reset values.
- in_valid in IDLE or DONE: the sample is not consumed. The upstream stage must hold it.

Test Plan:
1. Reset, then len=4 with four samples 0x400000 (+1.0), in_valid continuous -> done high for exactly 1 cycle, one cycle after the 4th accept; sum=0x0001000000; overflow=0; in_ready=0 after the 4th accept.
2. len=3 with samples 0xC00000 (-1.0), 0x200000 (+0.5), 0x100000 (+0.25), with in_valid gaps and clk_en low for 2 cycles mid-batch -> sum=0xFFFFF00000 (-0.25); exactly 3 accepts; done pulse held through the clk_en-low cycles.
3. len=0 start -> DONE on the next enabled edge; done=1 for one cycle; sum=0; no samples consumed, and in_ready stays 0 with in_valid=1.
4. ACC_W=26, len=8, all samples 0x400000 -> sum saturates at 0x1FFFFFF; overflow=1. A following batch (len=1, sample 0x000001) -> overflow=0, sum=0x0000001.
5. rst asserted asynchronously after 2 of 5 accepts -> state=IDLE, sum=0, done=0, busy=0 with no clock edge needed. A new start with len=1 completes normally.
6. start pulsed during ACCUM and DONE -> ignored; len is not re-captured; batch result unchanged; the block returns to IDLE.
